// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each stage adds one CW-bit chunk, and the carry
// ripples between stage registers. A single global advance enable provides valid/ready flow control.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             sub_i,
    input  logic             cin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic              en;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [CW:0]       part;

    function automatic logic [CW:0] chunk_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             c,
                                              input int               k);
        return {1'b0, a[k*CW +: CW]} + {1'b0, b[k*CW +: CW]} + {{CW{1'b0}}, c};
    endfunction

    // The whole pipeline moves together, so bubbles are never squeezed out during a stall
    assign en      = ~valid_o | ready_i;
    assign ready_o = en;

    always_comb begin
        vld_d = '0;
        cry_d = '0;
        opa_d = '{default: '0};
        opb_d = '{default: '0};
        sum_d = '{default: '0};
        part  = '0;

        opa_d[0] = src1_i;
        opb_d[0] = sub_i ? ~src2_i : src2_i;
        part     = chunk_add(opa_d[0], opb_d[0], sub_i | cin_i, 0);
        sum_d[0][CW-1:0] = part[CW-1:0];
        cry_d[0] = part[CW];
        vld_d[0] = valid_i;

        for (int k = 1; k < STAGES; k++) begin
            opa_d[k] = opa_q[k-1];
            opb_d[k] = opb_q[k-1];
            part     = chunk_add(opa_q[k-1], opb_q[k-1], cry_q[k-1], k);
            sum_d[k] = sum_q[k-1];
            sum_d[k][k*CW +: CW] = part[CW-1:0];
            cry_d[k] = part[CW];
            vld_d[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            cry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else if (en) begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    // The last stage still carries A and the post-inversion B, so overflow uses their sign bits
    assign valid_o    = vld_q[LAST];
    assign sum_o      = sum_q[LAST];
    assign carry_o    = cry_q[LAST];
    assign overflow_o = (opa_q[LAST][WIDTH-1] == opb_q[LAST][WIDTH-1]) &
                        (sum_q[LAST][WIDTH-1] != opa_q[LAST][WIDTH-1]);

endmodule
